// File: rtl/d7_pkg.sv
// rtl/d7_pkg.sv - shared constants and types for the 8-digit 7-segment scan driver
package d7_pkg;

  // Display geometry
  localparam int CODE_W     = 5;
  localparam int NUM_DIGITS = 8;
  localparam int IDX_W      = $clog2(NUM_DIGITS);
  localparam int CHARS_W    = CODE_W * NUM_DIGITS;

  // Character codes above the hex range (0-15 are the hex digits)
  localparam logic [CODE_W-1:0] CH_BLANK = 5'd16;
  localparam logic [CODE_W-1:0] CH_L     = 5'd17;
  localparam logic [CODE_W-1:0] CH_U     = 5'd18;
  localparam logic [CODE_W-1:0] CH_DASH  = 5'd19;
  localparam logic [CODE_W-1:0] CH_H     = 5'd20;
  localparam logic [CODE_W-1:0] CH_P     = 5'd21;
  localparam logic [CODE_W-1:0] CH_R     = 5'd22;
  localparam logic [CODE_W-1:0] CH_O     = 5'd23;

  // Segment patterns {g,f,e,d,c,b,a}, 1 = segment lit
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_L     = 7'h38;
  localparam logic [6:0] SEG_U     = 7'h3E;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_H     = 7'h76;
  localparam logic [6:0] SEG_P     = 7'h73;
  localparam logic [6:0] SEG_R     = 7'h50;
  localparam logic [6:0] SEG_O     = 7'h5C;

  // Phase within a digit slot
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

endpackage

// File: rtl/d7_scan_driver_if.sv
// rtl/d7_scan_driver_if.sv - display string load port and pin outputs of the scan driver
interface d7_scan_driver_if;

  logic [d7_pkg::CHARS_W-1:0]    chars_in;
  logic [d7_pkg::NUM_DIGITS-1:0] dp_in;
  logic                          load;
  logic                          enable;
  logic [d7_pkg::NUM_DIGITS-1:0] d7_anodes;
  logic [7:0]                    d7_cathodes;
  logic                          frame_start;

  // Application side: writes strings, observes the pins
  modport master (
    output chars_in, dp_in, load, enable,
    input  d7_anodes, d7_cathodes, frame_start
  );

  // Driver side
  modport slave (
    input  chars_in, dp_in, load, enable,
    output d7_anodes, d7_cathodes, frame_start
  );

endinterface

// File: rtl/d7_font_rom.sv
// rtl/d7_font_rom.sv - character code plus dp bit to active-low cathode pattern
module d7_font_rom
  import d7_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  input  logic              dp_i,
  output logic [7:0]        cathodes_o
);

  logic [6:0] seg;

  // Character lookup; unused codes fall through to blank
  always_comb begin
    seg = SEG_BLANK;
    case (code_i)
      5'd0:     seg = SEG_0;
      5'd1:     seg = SEG_1;
      5'd2:     seg = SEG_2;
      5'd3:     seg = SEG_3;
      5'd4:     seg = SEG_4;
      5'd5:     seg = SEG_5;
      5'd6:     seg = SEG_6;
      5'd7:     seg = SEG_7;
      5'd8:     seg = SEG_8;
      5'd9:     seg = SEG_9;
      5'd10:    seg = SEG_A;
      5'd11:    seg = SEG_B;
      5'd12:    seg = SEG_C;
      5'd13:    seg = SEG_D;
      5'd14:    seg = SEG_E;
      5'd15:    seg = SEG_F;
      CH_L:     seg = SEG_L;
      CH_U:     seg = SEG_U;
      CH_DASH:  seg = SEG_DASH;
      CH_H:     seg = SEG_H;
      CH_P:     seg = SEG_P;
      CH_R:     seg = SEG_R;
      CH_O:     seg = SEG_O;
      default:  seg = SEG_BLANK;
    endcase
  end

  // Pins are active-low, dp in the top bit
  assign cathodes_o = ~{dp_i, seg};

endmodule

// File: rtl/d7_scan_driver.sv
// rtl/d7_scan_driver.sv - multiplexed 8-digit 7-segment driver with blanking and tear-free loads
module d7_scan_driver
  import d7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 1500,
  parameter int BLANK_CYCLES = 16
) (
  input logic            clk,
  input logic            reset,
  d7_scan_driver_if.slave bus
);

  localparam int                 CNT_W     = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  slot_end;
  logic                  frame_end;

  logic [CHARS_W-1:0]    shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [CHARS_W-1:0]    active_q, active_d;
  logic [NUM_DIGITS-1:0] active_dp_q, active_dp_d;
  logic                  pending_q, pending_d;

  logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
  logic [7:0]            cathodes_q, cathodes_d;
  logic                  frame_start_q, frame_start_d;

  phase_e                phase_d;
  logic [CODE_W-1:0]     code_sel;
  logic                  dp_sel;
  logic [7:0]            font_cathodes;

  // Slot counter and digit index advance; the frame boundary is the last cycle of digit 7
  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    idx_d     = slot_end ? idx_q + 1'b1 : idx_q;
  end

  // Shadow capture on load; shadow moves to active only at a frame boundary
  always_comb begin
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    active_d    = active_q;
    active_dp_d = active_dp_q;
    pending_d   = pending_q;
    if (frame_end && pending_q) begin
      active_d    = shadow_q;
      active_dp_d = shadow_dp_q;
      pending_d   = 1'b0;
    end
    // A load on the boundary cycle is captured after the old shadow was applied
    if (bus.load) begin
      shadow_d    = bus.chars_in;
      shadow_dp_d = bus.dp_in;
      pending_d   = 1'b1;
    end
  end

  // Decode the digit about to be shown, using the post-boundary active data
  always_comb begin
    code_sel = active_d[int'(idx_d) * CODE_W +: CODE_W];
    dp_sel   = active_dp_d[idx_d];
  end

  d7_font_rom u_font_rom (
    .code_i     (code_sel),
    .dp_i       (dp_sel),
    .cathodes_o (font_cathodes)
  );

  // Next pin values: anodes off through the blank phase, cathodes swap only when anodes are off
  always_comb begin
    phase_d       = (cnt_d < CNT_BLANK) ? PH_BLANK : PH_DRIVE;
    anodes_d      = '0;
    if (phase_d == PH_DRIVE && bus.enable) begin
      anodes_d = NUM_DIGITS'(1) << idx_d;
    end
    cathodes_d    = slot_end ? font_cathodes : cathodes_q;
    frame_start_d = frame_end;
  end

  // Scan position registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Character store registers; reset discards any pending load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q    <= {NUM_DIGITS{CH_BLANK}};
      shadow_dp_q <= '0;
      active_q    <= {NUM_DIGITS{CH_BLANK}};
      active_dp_q <= '0;
      pending_q   <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      active_q    <= active_d;
      active_dp_q <= active_dp_d;
      pending_q   <= pending_d;
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anodes_q      <= '0;
      cathodes_q    <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      anodes_q      <= anodes_d;
      cathodes_q    <= cathodes_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.d7_anodes   = anodes_q;
  assign bus.d7_cathodes = cathodes_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_d7_scan_driver.sv
// tb/tb_d7_scan_driver.sv - scoreboard bench for the 7-segment scan driver
module tb_d7_scan_driver;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  logic [15:0] sb_q[$];
  logic [15:0] obs_q[$];

  d7_scan_driver_if bus();

  d7_scan_driver #(
    .DIGIT_CYCLES (20),
    .BLANK_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [39:0] fill(input logic [4:0] c);
    return {8{c}};
  endfunction

  task automatic do_load(input logic [39:0] chars, input logic [7:0] dp);
    bus.chars_in = chars;
    bus.dp_in    = dp;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  task automatic wait_frame_start(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame_start !== 1'b1 && n < 400);
    vectors++;
    if (bus.frame_start !== 1'b1) begin
      miscompares++;
      $display("FAIL %s frame_start: got %b after %0d cycles, need 1", tag, bus.frame_start, n);
    end
  endtask

  task automatic wait_anodes(input logic [7:0] an, input string tag);
    int n;
    n = 0;
    while (bus.d7_anodes !== an && n < 400) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.d7_anodes !== an) begin
      miscompares++;
      $display("FAIL %s wait anodes: got %h, need %h", tag, bus.d7_anodes, an);
    end
  endtask

  // Records {anodes, cathodes} at each rise of the anodes from all-off
  task automatic capture(input int n);
    int got;
    int cyc;
    logic [7:0] prev;
    got  = 0;
    cyc  = 0;
    prev = bus.d7_anodes;
    obs_q.delete();
    while (got < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bus.d7_anodes !== 8'h00 && prev === 8'h00) begin
        obs_q.push_back({bus.d7_anodes, bus.d7_cathodes});
        got++;
      end
      prev = bus.d7_anodes;
    end
  endtask

  task automatic test_reset;
    logic [15:0] e, g;
    int n;
    reset        = 1'b1;
    bus.enable   = 1'b1;
    bus.load     = 1'b0;
    bus.chars_in = fill(5'd16);
    bus.dp_in    = 8'h00;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.d7_anodes !== 8'h00) begin miscompares++; $display("FAIL por anodes: got %h need 00", bus.d7_anodes); end
    vectors++;
    if (bus.d7_cathodes !== 8'hFF) begin miscompares++; $display("FAIL por cathodes: got %h need ff", bus.d7_cathodes); end
    vectors++;
    if (bus.frame_start !== 1'b0) begin miscompares++; $display("FAIL por frame_start: got %b need 0", bus.frame_start); end
    reset = 1'b0;
    do_load(fill(5'd8), 8'h00);
    wait_frame_start("reset");
    wait_anodes(8'h04, "reset");
    vectors++;
    if (bus.d7_cathodes !== 8'h80) begin miscompares++; $display("FAIL pre-reset cathodes: got %h need 80", bus.d7_cathodes); end
    do_load({5'd16, 5'd16, 5'd18, 5'd17, 5'd16, 5'd16, 5'd16, 5'd16}, 8'h00);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (bus.d7_anodes !== 8'h00) begin miscompares++; $display("FAIL async reset anodes: got %h need 00", bus.d7_anodes); end
    vectors++;
    if (bus.d7_cathodes !== 8'hFF) begin miscompares++; $display("FAIL async reset cathodes: got %h need ff", bus.d7_cathodes); end
    vectors++;
    if (bus.frame_start !== 1'b0) begin miscompares++; $display("FAIL async reset frame_start: got %b need 0", bus.frame_start); end
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame_start !== 1'b1 && n < 400);
    vectors++;
    if (n != 160) begin miscompares++; $display("FAIL first frame_start after reset: got cycle %0d need 160", n); end
    for (int i = 0; i < 8; i++) sb_q.push_back({8'(1 << i), 8'hFF});
    capture(8);
    for (int i = 0; i < 8; i++) begin
      e = sb_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL reset blank slot %0d: got none need %h", i, e); end
      else begin
        g = obs_q.pop_front();
        if (g !== e) begin miscompares++; $display("FAIL reset blank slot %0d: got %h need %h", i, g, e); end
      end
    end
  endtask

  task automatic test_scan;
    int blank;
    int high;
    logic [7:0] an;
    wait_frame_start("scan");
    for (int d = 0; d < 8; d++) begin
      blank = 0;
      while (bus.d7_anodes === 8'h00 && blank < 50) begin blank++; @(negedge clk); end
      an = bus.d7_anodes;
      high = 0;
      while (bus.d7_anodes === an && high < 50) begin high++; @(negedge clk); end
      vectors++;
      if (blank != 4) begin miscompares++; $display("FAIL scan blank digit %0d: got %0d need 4", d, blank); end
      vectors++;
      if (an !== 8'(1 << d)) begin miscompares++; $display("FAIL scan order digit %0d: got %h need %h", d, an, 8'(1 << d)); end
      vectors++;
      if (high != 16) begin miscompares++; $display("FAIL scan drive digit %0d: got %0d need 16", d, high); end
    end
    vectors++;
    if (bus.frame_start !== 1'b1) begin miscompares++; $display("FAIL scan period frame_start: got %b need 1", bus.frame_start); end
  endtask

  task automatic test_ul;
    logic [15:0] e, g;
    do_load({5'd16, 5'd16, 5'd18, 5'd17, 5'd16, 5'd16, 5'd16, 5'd16}, 8'h00);
    wait_frame_start("ul");
    for (int i = 0; i < 8; i++)
      sb_q.push_back({8'(1 << i), (i == 4) ? 8'hC7 : (i == 5) ? 8'hC1 : 8'hFF});
    capture(8);
    for (int i = 0; i < 8; i++) begin
      e = sb_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL ul slot %0d: got none need %h", i, e); end
      else begin
        g = obs_q.pop_front();
        if (g !== e) begin miscompares++; $display("FAIL ul slot %0d: got %h need %h", i, g, e); end
      end
    end
  endtask

  task automatic test_tear_free;
    logic [15:0] e, g;
    wait_frame_start("tear");
    wait_anodes(8'h08, "tear");
    do_load(fill(5'd8), 8'h00);
    sb_q.push_back({8'h10, 8'hC7});
    sb_q.push_back({8'h20, 8'hC1});
    sb_q.push_back({8'h40, 8'hFF});
    sb_q.push_back({8'h80, 8'hFF});
    capture(4);
    for (int i = 0; i < 4; i++) begin
      e = sb_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL tear old slot %0d: got none need %h", i + 4, e); end
      else begin
        g = obs_q.pop_front();
        if (g !== e) begin miscompares++; $display("FAIL tear old slot %0d: got %h need %h", i + 4, g, e); end
      end
    end
    wait_frame_start("tear");
    for (int i = 0; i < 8; i++) sb_q.push_back({8'(1 << i), 8'h80});
    capture(8);
    for (int i = 0; i < 8; i++) begin
      e = sb_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL tear new slot %0d: got none need %h", i, e); end
      else begin
        g = obs_q.pop_front();
        if (g !== e) begin miscompares++; $display("FAIL tear new slot %0d: got %h need %h", i, g, e); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] e, g;
    wait_frame_start("b2b");
    do_load(fill(5'd10), 8'h00);
    repeat (20) @(negedge clk);
    do_load(fill(5'd11), 8'h00);
    wait_frame_start("b2b");
    for (int i = 0; i < 8; i++) sb_q.push_back({8'(1 << i), 8'h83});
    capture(8);
    for (int i = 0; i < 8; i++) begin
      e = sb_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL b2b slot %0d: got none need %h", i, e); end
      else begin
        g = obs_q.pop_front();
        if (g !== e) begin miscompares++; $display("FAIL b2b slot %0d: got %h need %h", i, g, e); end
      end
    end
  endtask

  task automatic test_boundary_load;
    logic [15:0] e, g;
    wait_frame_start("bnd");
    do_load(fill(5'd13), 8'h00);
    repeat (158) @(negedge clk);
    do_load(fill(5'd12), 8'h00);
    vectors++;
    if (bus.frame_start !== 1'b1) begin miscompares++; $display("FAIL bnd alignment frame_start: got %b need 1", bus.frame_start); end
    for (int i = 0; i < 8; i++) sb_q.push_back({8'(1 << i), 8'hA1});
    capture(8);
    for (int i = 0; i < 8; i++) begin
      e = sb_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL bnd old slot %0d: got none need %h", i, e); end
      else begin
        g = obs_q.pop_front();
        if (g !== e) begin miscompares++; $display("FAIL bnd old slot %0d: got %h need %h", i, g, e); end
      end
    end
    wait_frame_start("bnd");
    for (int i = 0; i < 8; i++) sb_q.push_back({8'(1 << i), 8'hC6});
    capture(8);
    for (int i = 0; i < 8; i++) begin
      e = sb_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL bnd new slot %0d: got none need %h", i, e); end
      else begin
        g = obs_q.pop_front();
        if (g !== e) begin miscompares++; $display("FAIL bnd new slot %0d: got %h need %h", i, g, e); end
      end
    end
  endtask

  task automatic test_enable_dp;
    logic [15:0] e, g;
    int lit;
    int starts;
    int n;
    do_load({5'd16, 5'd16, 5'd16, 5'd16, 5'd16, 5'd16, 5'd16, 5'd0}, 8'h01);
    wait_frame_start("en");
    for (int i = 0; i < 8; i++) sb_q.push_back({8'(1 << i), (i == 0) ? 8'h40 : 8'hFF});
    capture(8);
    for (int i = 0; i < 8; i++) begin
      e = sb_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL dp slot %0d: got none need %h", i, e); end
      else begin
        g = obs_q.pop_front();
        if (g !== e) begin miscompares++; $display("FAIL dp slot %0d: got %h need %h", i, g, e); end
      end
    end
    wait_anodes(8'h01, "en");
    bus.enable = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.d7_anodes !== 8'h00) begin miscompares++; $display("FAIL enable latency anodes: got %h need 00", bus.d7_anodes); end
    lit = 0;
    starts = 0;
    n = 0;
    while (starts < 2 && n < 500) begin
      @(negedge clk);
      n++;
      if (bus.d7_anodes !== 8'h00) lit++;
      if (bus.frame_start === 1'b1) starts++;
    end
    vectors++;
    if (lit != 0) begin miscompares++; $display("FAIL enable off anodes: got %0d lit cycles need 0", lit); end
    vectors++;
    if (starts != 2) begin miscompares++; $display("FAIL enable off frame_start: got %0d pulses need 2", starts); end
    bus.enable = 1'b1;
    sb_q.push_back({8'h01, 8'h40});
    capture(1);
    e = sb_q.pop_front();
    vectors++;
    if (obs_q.size() == 0) begin miscompares++; $display("FAIL re-enable slot 0: got none need %h", e); end
    else begin
      g = obs_q.pop_front();
      if (g !== e) begin miscompares++; $display("FAIL re-enable slot 0: got %h need %h", g, e); end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_scan();
    test_ul();
    test_tear_free();
    test_back_to_back();
    test_boundary_load();
    test_enable_dp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
